branch_target_table: RTL

- Programmable branch-target store: maps an 8-bit branch label to a 12-bit next PC.
- Replaces the hard-coded label-to-target case table with a writable table.
- The program loader fills it at load time; the fetch/branch unit reads it at run time.
- Holds BANKS independent tables, one per program image.
- Adds valid tracking, hit/miss reporting, a 1-cycle registered read with write bypass, and a sequential per-bank clear.

---
 rtl/btt_pkg.sv | 16 +
 rtl/branch_target_table_if.sv | 43 ++++
 rtl/btt_bank.sv | 47 ++++
 rtl/branch_target_table.sv | 133 +++++++++++++
 4 files changed

// File: rtl/btt_pkg.sv
// Shared types and defaults for the branch target table: label/PC widths,
// their typedefs, and the clear-sweep FSM state encoding.
package btt_pkg;

    localparam int BTT_LABEL_W = 8;
    localparam int BTT_PC_W    = 12;

    typedef logic [BTT_LABEL_W-1:0] label_t;
    typedef logic [BTT_PC_W-1:0]    pc_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } btt_state_e;

endpackage

// File: rtl/branch_target_table_if.sv
// Loader/fetch-side bus of the branch target table. The master (loader and
// fetch unit) drives writes, lookups and clear requests; the slave answers.
interface branch_target_table_if
    import btt_pkg::*;
#(
    parameter int LABEL_W = BTT_LABEL_W,
    parameter int PC_W    = BTT_PC_W,
    parameter int BANK_W  = 1
) ();

    // Lookup handshake: rd_en is a one-cycle request with no back-pressure;
    // rd_valid pulses exactly one cycle later per accepted request, and
    // next_pc/hit keep their last value whenever rd_valid is low.
    logic               wr_en;
    logic [BANK_W-1:0]  wr_bank;
    logic [LABEL_W-1:0] wr_label;
    logic [PC_W-1:0]    wr_target;
    logic               rd_en;
    logic [BANK_W-1:0]  rd_bank;
    logic [LABEL_W-1:0] rd_label;
    logic               rd_valid;
    logic [PC_W-1:0]    next_pc;
    logic               hit;
    logic               clr_req;
    logic [BANK_W-1:0]  clr_bank;
    logic               busy;
    btt_state_e         dbg_state;

    modport master (
        output wr_en, wr_bank, wr_label, wr_target,
        output rd_en, rd_bank, rd_label,
        output clr_req, clr_bank,
        input  rd_valid, next_pc, hit, busy, dbg_state
    );

    modport slave (
        input  wr_en, wr_bank, wr_label, wr_target,
        input  rd_en, rd_bank, rd_label,
        input  clr_req, clr_bank,
        output rd_valid, next_pc, hit, busy, dbg_state
    );

endinterface

// File: rtl/btt_bank.sv
// One bank of the branch target table: DEPTH x PC_W targets plus a valid
// vector, with write, single-index clear and combinational read.
module btt_bank #(
    parameter int DEPTH = 64,
    parameter int PC_W  = 12,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [PC_W-1:0]  i_wr_target,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_hit,
    output logic [PC_W-1:0]  o_rd_target
);

    logic [PC_W-1:0]  r_target [DEPTH];
    logic [DEPTH-1:0] r_valid;

    // Targets carry no reset so the array can map onto RAM; validity alone
    // decides whether a stored target is visible.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
            end
            if (i_clr_en) begin
                r_valid[i_clr_idx] <= 1'b0;
            end
        end
    end

    assign o_rd_hit    = r_valid[i_rd_idx];
    assign o_rd_target = r_target[i_rd_idx];

endmodule

// File: rtl/branch_target_table.sv
// Banked, writable label -> next-PC table with registered lookup, write-first
// bypass and a one-entry-per-cycle clear sweep of a selected bank.
module branch_target_table
    import btt_pkg::*;
#(
    parameter  int LABEL_W = BTT_LABEL_W,
    parameter  int PC_W    = BTT_PC_W,
    parameter  int DEPTH   = 64,
    parameter  int BANKS   = 2,
    localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_target_table_if.slave bus
);

    btt_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [BANK_W-1:0] r_clr_bank, w_clr_bank_nxt;

    logic             w_wr_ok;
    logic             w_rd_in_range;
    logic             w_rd_blocked;
    logic             w_bypass;
    logic             w_hit;
    logic [PC_W-1:0]  w_pc;
    logic [BANKS-1:0] w_bank_hit;
    logic [PC_W-1:0]  w_bank_target [BANKS];

    logic             r_rd_valid;
    logic             r_hit;
    logic [PC_W-1:0]  r_next_pc;

    assign w_wr_ok = (r_state == IDLE) && bus.wr_en &&
                     (32'(bus.wr_label) < DEPTH) && (32'(bus.wr_bank) < BANKS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_clr_bank <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_clr_bank <= w_clr_bank_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_clr_bank_nxt = r_clr_bank;
        case (r_state)
            IDLE: begin
                if (bus.clr_req && (32'(bus.clr_bank) < BANKS)) begin
                    w_state_nxt    = CLEAR;
                    w_idx_nxt      = '0;
                    w_clr_bank_nxt = bus.clr_bank;
                end
            end
            CLEAR: begin
                if (r_idx == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        btt_bank #(
            .DEPTH (DEPTH),
            .PC_W  (PC_W),
            .IDX_W (IDX_W)
        ) u_bank (
            .clk         (clk),
            .reset       (reset),
            .i_wr_en     (w_wr_ok && (bus.wr_bank == BANK_W'(b))),
            .i_wr_idx    (bus.wr_label[IDX_W-1:0]),
            .i_wr_target (bus.wr_target),
            .i_clr_en    ((r_state == CLEAR) && (r_clr_bank == BANK_W'(b))),
            .i_clr_idx   (r_idx),
            .i_rd_idx    (bus.rd_label[IDX_W-1:0]),
            .o_rd_hit    (w_bank_hit[b]),
            .o_rd_target (w_bank_target[b])
        );
    end

    // A bank under sweep reads as empty from the first sweep cycle, so
    // half-cleared contents are never observable.
    always_comb begin
        w_rd_in_range = (32'(bus.rd_label) < DEPTH) && (32'(bus.rd_bank) < BANKS);
        w_rd_blocked  = (r_state == CLEAR) && (bus.rd_bank == r_clr_bank);
        w_bypass      = w_wr_ok && (bus.wr_bank == bus.rd_bank) &&
                        (bus.wr_label == bus.rd_label);
        w_hit         = 1'b0;
        w_pc          = '0;
        if (w_rd_in_range && !w_rd_blocked) begin
            if (w_bypass) begin
                w_hit = 1'b1;
                w_pc  = bus.wr_target;
            end else if (w_bank_hit[bus.rd_bank]) begin
                w_hit = 1'b1;
                w_pc  = w_bank_target[bus.rd_bank];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_hit      <= 1'b0;
            r_next_pc  <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_hit     <= w_hit;
                r_next_pc <= w_pc;
            end
        end
    end

    assign bus.rd_valid  = r_rd_valid;
    assign bus.hit       = r_hit;
    assign bus.next_pc   = r_next_pc;
    assign bus.busy      = (r_state == CLEAR);
    assign bus.dbg_state = r_state;

endmodule
